multicycle_control: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/ctrl_output_decode.sv | 72 +++++++
 rtl/multicycle_control.sv | 79 +++++++
 tb/tb_multicycle_control.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state, opcode and control encodings; legality of j depends on JUMP_EN
package cpu_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_RTEXEC   = 4'd6,
        S_RTWB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IEXEC    = 4'd10,
        S_IWB      = 4'd11
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_LOGIC = 2'd3;
    localparam logic [1:0] SRCB_REG   = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;
    function automatic logic is_legal(input logic [5:0] op);
`ifdef JUMP_EN
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J};
`else
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI};
`endif
    endfunction
endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode: state -> control word; JUMP outputs exist only with JUMP_EN
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t      st,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output ctrl_t       c
);
    // Moore decode, with fetch writes gated by memory and the illegal pulse in decode
    always_comb begin
        c = '0;
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_IMMSH;
                c.ext_op     = 1'b1;
                c.illegal_op = !is_legal(op);
            end
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.ext_op    = 1'b1;
            end
            S_MEMREAD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_RTEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
`ifdef JUMP_EN
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
`endif
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.ext_op    = (op == OP_ADDI);
                c.alu_op    = (op == OP_ADDI) ? ALU_ADD : ALU_LOGIC;
            end
            S_IWB: c.reg_write = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS main control FSM; define JUMP_EN to decode j
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Op,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               ExtOp,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);
    state_t st;
    ctrl_t  c;
    // state register and next-state sequencing; reset wins over MemReady
    always_ff @(posedge clk) begin
        if (rst) st <= S_FETCH;
        else begin
            case (st)
                S_FETCH:    st <= MemReady ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW:               st <= S_MEMADDR;
                        OP_RTYPE:                   st <= S_RTEXEC;
                        OP_BEQ:                     st <= S_BRANCH;
                        OP_ADDI, OP_ANDI, OP_ORI:   st <= S_IEXEC;
`ifdef JUMP_EN
                        OP_J:                       st <= S_JUMP;
`endif
                        default:                    st <= S_FETCH;
                    endcase
                end
                S_MEMADDR:  st <= (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  st <= MemReady ? S_MEMWB : S_MEMREAD;
                S_MEMWRITE: st <= MemReady ? S_FETCH : S_MEMWRITE;
                S_RTEXEC:   st <= S_RTWB;
                S_IEXEC:    st <= S_IWB;
                default:    st <= S_FETCH;
            endcase
        end
    end
    ctrl_output_decode u_dec (
        .st(st),
        .op(Op),
        .mem_ready(MemReady),
        .c(c)
    );
    assign PCWrite     = c.pc_write;
    assign PCWriteCond = c.pc_write_cond;
    assign IorD        = c.iord;
    assign MemRead     = c.mem_read;
    assign MemWrite    = c.mem_write;
    assign IRWrite     = c.ir_write;
    assign MemtoReg    = c.mem_to_reg;
    assign RegDst      = c.reg_dst;
    assign RegWrite    = c.reg_write;
    assign ALUSrcA     = c.alu_src_a;
    assign ExtOp       = c.ext_op;
    assign ALUSrcB     = c.alu_src_b;
    assign ALUOp       = c.alu_op;
    assign PCSource    = c.pc_source;
    assign IllegalOp   = c.illegal_op;
    assign State       = STATE_W'(st);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of the multicycle control FSM (default build, JUMP_EN undefined)
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = 6'b000000;
    logic       MemReady = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtOp, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;
    int checks = 0;
    int errors = 0;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ExtOp(ExtOp), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_state", 8'(State), 8'd0);
        chk("reset_irwrite", 8'(IRWrite), 8'd0);
        chk("reset_pcwrite", 8'(PCWrite), 8'd0);
        chk("reset_memread", 8'(MemRead), 8'd1);
        chk("reset_srcb", 8'(ALUSrcB), 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_state", 8'(State), 8'd0);
            chk("wait_irwrite", 8'(IRWrite), 8'd0);
            chk("wait_pcwrite", 8'(PCWrite), 8'd0);
        end
        MemReady = 1'b1;
        #1;
        chk("ready_irwrite", 8'(IRWrite), 8'd1);
        chk("ready_pcwrite", 8'(PCWrite), 8'd1);
        tick();
        chk("decode_state", 8'(State), 8'd1);
        chk("decode_extop", 8'(ExtOp), 8'd1);
        chk("decode_srcb", 8'(ALUSrcB), 8'd3);
        chk("decode_legal", 8'(IllegalOp), 8'd0);
        chk("decode_pcwrite", 8'(PCWrite), 8'd0);
        tick();
        chk("rt_exec_state", 8'(State), 8'd6);
        chk("rt_exec_aluop", 8'(ALUOp), 8'd2);
        chk("rt_exec_srca", 8'(ALUSrcA), 8'd1);
        chk("rt_exec_srcb", 8'(ALUSrcB), 8'd0);
        tick();
        chk("rt_wb_state", 8'(State), 8'd7);
        chk("rt_wb_regdst", 8'(RegDst), 8'd1);
        chk("rt_wb_regwrite", 8'(RegWrite), 8'd1);
        tick();
        chk("rt_done", 8'(State), 8'd0);

        Op = 6'b100011;
        tick();
        chk("lw_s1", 8'(State), 8'd1);
        tick();
        chk("lw_s2", 8'(State), 8'd2);
        chk("lw_addr_srcb", 8'(ALUSrcB), 8'd2);
        chk("lw_addr_extop", 8'(ExtOp), 8'd1);
        chk("lw_addr_srca", 8'(ALUSrcA), 8'd1);
        tick();
        chk("lw_s3", 8'(State), 8'd3);
        chk("lw_rd_memread", 8'(MemRead), 8'd1);
        chk("lw_rd_iord", 8'(IorD), 8'd1);
        chk("lw_rd_regwrite", 8'(RegWrite), 8'd0);
        tick();
        chk("lw_s4", 8'(State), 8'd4);
        chk("lw_wb_regwrite", 8'(RegWrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(MemtoReg), 8'd1);
        chk("lw_wb_regdst", 8'(RegDst), 8'd0);
        tick();
        chk("lw_s0", 8'(State), 8'd0);

        Op = 6'b001101;
        tick();
        tick();
        chk("ori_state", 8'(State), 8'd10);
        chk("ori_extop", 8'(ExtOp), 8'd0);
        chk("ori_aluop", 8'(ALUOp), 8'd3);
        chk("ori_srcb", 8'(ALUSrcB), 8'd2);
        tick();
        chk("ori_wb_state", 8'(State), 8'd11);
        chk("ori_wb_regwrite", 8'(RegWrite), 8'd1);
        tick();
        chk("ori_done", 8'(State), 8'd0);

        Op = 6'b001000;
        tick();
        tick();
        chk("addi_state", 8'(State), 8'd10);
        chk("addi_extop", 8'(ExtOp), 8'd1);
        chk("addi_aluop", 8'(ALUOp), 8'd0);
        tick();
        tick();
        chk("addi_done", 8'(State), 8'd0);

        Op = 6'b101011;
        tick();
        tick();
        tick();
        MemReady = 1'b0;
        #1;
        chk("sw_state_a", 8'(State), 8'd5);
        chk("sw_memwrite_a", 8'(MemWrite), 8'd1);
        chk("sw_iord_a", 8'(IorD), 8'd1);
        chk("sw_regwrite_a", 8'(RegWrite), 8'd0);
        tick();
        chk("sw_state_b", 8'(State), 8'd5);
        chk("sw_memwrite_b", 8'(MemWrite), 8'd1);
        tick();
        chk("sw_state_c", 8'(State), 8'd5);
        MemReady = 1'b1;
        #1;
        chk("sw_memwrite_c", 8'(MemWrite), 8'd1);
        chk("sw_regwrite_c", 8'(RegWrite), 8'd0);
        tick();
        chk("sw_done", 8'(State), 8'd0);
        chk("sw_done_memwrite", 8'(MemWrite), 8'd0);

        Op = 6'b000100;
        tick();
        chk("beq_s1", 8'(State), 8'd1);
        tick();
        chk("beq_s8", 8'(State), 8'd8);
        chk("beq_pcwritecond", 8'(PCWriteCond), 8'd1);
        chk("beq_aluop", 8'(ALUOp), 8'd1);
        chk("beq_pcsource", 8'(PCSource), 8'd1);
        chk("beq_srca", 8'(ALUSrcA), 8'd1);
        chk("beq_srcb", 8'(ALUSrcB), 8'd0);
        tick();
        chk("beq_done", 8'(State), 8'd0);

        Op = 6'b111111;
        tick();
        chk("ill_state", 8'(State), 8'd1);
        chk("ill_pulse", 8'(IllegalOp), 8'd1);
        tick();
        chk("ill_back", 8'(State), 8'd0);
        chk("ill_clear", 8'(IllegalOp), 8'd0);

        Op = 6'b000010;
        tick();
        chk("j_state", 8'(State), 8'd1);
        chk("j_illegal", 8'(IllegalOp), 8'd1);
        chk("j_pcsource", 8'(PCSource), 8'd0);
        tick();
        chk("j_back", 8'(State), 8'd0);
        chk("j_pcwrite", 8'(PCWrite), 8'd1);

        Op = 6'b100011;
        tick();
        tick();
        tick();
        chk("abort_memread", 8'(State), 8'd3);
        rst = 1'b1;
        #1;
        chk("abort_regwrite_a", 8'(RegWrite), 8'd0);
        tick();
        chk("abort_state", 8'(State), 8'd0);
        chk("abort_regwrite_b", 8'(RegWrite), 8'd0);
        tick();
        chk("rst_beats_ready", 8'(State), 8'd0);
        rst = 1'b0;
        MemReady = 1'b0;
        #1;
        chk("post_rst_pcwrite", 8'(PCWrite), 8'd0);
        chk("post_rst_irwrite", 8'(IRWrite), 8'd0);
        tick();
        chk("post_rst_hold", 8'(State), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
